// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID_ctrl field layout and common control constants.
package pipe_pkg;

  localparam int CTRL_W = 14;

  // Field positions inside the packed decoder bundle, MSB first
  localparam int CTRL_ALUSRC_B    = 13;
  localparam int CTRL_MEMTOREG_HI = 12;
  localparam int CTRL_MEMTOREG_LO = 11;
  localparam int CTRL_JUMP_HI     = 10;
  localparam int CTRL_JUMP_LO     = 9;
  localparam int CTRL_BRANCH      = 8;
  localparam int CTRL_BRANCHN     = 7;
  localparam int CTRL_REGWRITE    = 6;
  localparam int CTRL_MEMRW       = 5;
  localparam int CTRL_ALU_HI      = 4;
  localparam int CTRL_ALU_LO      = 1;
  localparam int CTRL_ILL_INSTR   = 0;

  localparam logic [1:0]        MEMTOREG_LOAD = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_NOP      = '0;

  function automatic logic [1:0] ctrl_memtoreg(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMTOREG_HI:CTRL_MEMTOREG_LO];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the ID consumer.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic [1:0] ex_memtoreg,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       flush,
  output logic       hazard,
  output logic       load_use_stall
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd);
  assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd);

  assign hazard = ex_valid && (ex_memtoreg == MEMTOREG_LOAD) && (ex_rd != 5'd0)
                  && id_valid && (rs1_match || rs2_match);

  // A flush redirects IF anyway, so the stall must not hold the PC
  assign load_use_stall = hazard && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external stall.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_ext,
  input  logic              flush,
  input  logic              ID_valid,
  input  logic [31:0]       ID_PC,
  input  logic [4:0]        ID_rs1_addr,
  input  logic [4:0]        ID_rs2_addr,
  input  logic [4:0]        ID_rd,
  input  logic              ID_Rs1_used,
  input  logic              ID_Rs2_used,
  input  logic [31:0]       ID_rs1_data,
  input  logic [31:0]       ID_rs2_data,
  input  logic [31:0]       ID_imm,
  input  logic [CTRL_W-1:0] ID_ctrl,
  output logic              EX_valid,
  output logic [31:0]       EX_PC,
  output logic [4:0]        EX_rs1_addr,
  output logic [4:0]        EX_rs2_addr,
  output logic [4:0]        EX_rd,
  output logic [31:0]       EX_rs1_data,
  output logic [31:0]       EX_rs2_data,
  output logic [31:0]       EX_imm,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic              load_use_stall
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  logic       hazard;
  logic       take_bubble;
  logic [1:0] ex_memtoreg;

  assign ex_memtoreg = ctrl_memtoreg(EX_ctrl);

  hazard_detect u_hazard_detect (
    .ex_valid       (EX_valid),
    .ex_memtoreg    (ex_memtoreg),
    .ex_rd          (EX_rd),
    .id_valid       (ID_valid),
    .id_rs1_addr    (ID_rs1_addr),
    .id_rs2_addr    (ID_rs2_addr),
    .id_rs1_used    (ID_Rs1_used),
    .id_rs2_used    (ID_Rs2_used),
    .flush          (flush),
    .hazard         (hazard),
    .load_use_stall (load_use_stall)
  );

  assign take_bubble = flush || hazard;

  // Priority: reset, external stall (hold everything), bubble, then load
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_valid    <= 1'b0;
      EX_PC       <= '0;
      EX_rs1_addr <= '0;
      EX_rs2_addr <= '0;
      EX_rd       <= '0;
      EX_rs1_data <= '0;
      EX_rs2_data <= '0;
      EX_imm      <= '0;
      EX_ctrl     <= CTRL_NOP;
    end else if (!stall_ext) begin
      if (take_bubble) begin
        EX_valid    <= 1'b0;
        EX_PC       <= '0;
        EX_rs1_addr <= '0;
        EX_rs2_addr <= '0;
        EX_rd       <= '0;
        EX_rs1_data <= '0;
        EX_rs2_data <= '0;
        EX_imm      <= '0;
        EX_ctrl     <= CTRL_NOP;
      end else begin
        EX_valid    <= ID_valid;
        EX_PC       <= ID_PC;
        EX_rs1_addr <= ID_rs1_addr;
        EX_rs2_addr <= ID_rs2_addr;
        EX_rd       <= ID_rd;
        EX_rs1_data <= ID_rs1_data;
        EX_rs2_data <= ID_rs2_data;
        EX_imm      <= ID_imm;
        // An empty slot must never carry write or branch enables
        EX_ctrl     <= ID_valid ? ID_ctrl : CTRL_NOP;
      end
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!stall_ext && take_bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  // Without the counter, take_bubble only steers the EX register update.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model plus directed vectors.
module tb_id_ex_stage;

  localparam logic [13:0] C_NOP  = 14'h0000;
  localparam logic [13:0] C_LOAD = 14'h0840;
  localparam logic [13:0] C_ADD  = 14'h0044;
  localparam logic [13:0] C_ILL  = 14'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ext;
  logic        flush;
  logic        ID_valid;
  logic [31:0] ID_PC;
  logic [4:0]  ID_rs1_addr;
  logic [4:0]  ID_rs2_addr;
  logic [4:0]  ID_rd;
  logic        ID_Rs1_used;
  logic        ID_Rs2_used;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [31:0] ID_imm;
  logic [13:0] ID_ctrl;
  logic        EX_valid;
  logic [31:0] EX_PC;
  logic [4:0]  EX_rs1_addr;
  logic [4:0]  EX_rs2_addr;
  logic [4:0]  EX_rd;
  logic [31:0] EX_rs1_data;
  logic [31:0] EX_rs2_data;
  logic [31:0] EX_imm;
  logic [13:0] EX_ctrl;
  logic        load_use_stall;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] m_cnt;
  logic        preset_toggle = 1'b0;
  logic        preset_seen   = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [13:0] ctrl;
  } ex_t;

  ex_t m;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_ext      (stall_ext),
    .flush          (flush),
    .ID_valid       (ID_valid),
    .ID_PC          (ID_PC),
    .ID_rs1_addr    (ID_rs1_addr),
    .ID_rs2_addr    (ID_rs2_addr),
    .ID_rd          (ID_rd),
    .ID_Rs1_used    (ID_Rs1_used),
    .ID_Rs2_used    (ID_Rs2_used),
    .ID_rs1_data    (ID_rs1_data),
    .ID_rs2_data    (ID_rs2_data),
    .ID_imm         (ID_imm),
    .ID_ctrl        (ID_ctrl),
    .EX_valid       (EX_valid),
    .EX_PC          (EX_PC),
    .EX_rs1_addr    (EX_rs1_addr),
    .EX_rs2_addr    (EX_rs2_addr),
    .EX_rd          (EX_rd),
    .EX_rs1_data    (EX_rs1_data),
    .EX_rs2_data    (EX_rs2_data),
    .EX_imm         (EX_imm),
    .EX_ctrl        (EX_ctrl),
    .load_use_stall (load_use_stall)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // A load in EX whose destination is read by a valid ID instruction
  function automatic logic model_hazard();
    logic reads_rd;
    reads_rd = (ID_Rs1_used && ID_rs1_addr == m.rd) || (ID_Rs2_used && ID_rs2_addr == m.rd);
    return m.valid && (m.ctrl[12:11] == 2'b01) && (m.rd != 5'd0) && ID_valid && reads_rd;
  endfunction

  always @(posedge clk) begin
    logic haz;
    haz = model_hazard();
`ifdef ID_EX_BUBBLE_CNT_EN
    if (preset_toggle != preset_seen) begin
      m_cnt       = 32'hFFFF_FFFF;
      preset_seen = preset_toggle;
    end
`endif
    if (rst) begin
      m = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
      m_cnt = 32'd0;
`endif
    end else if (!stall_ext) begin
      if (flush || haz) begin
        m = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
        m_cnt = m_cnt + 32'd1;
`endif
      end else begin
        m.valid = ID_valid;
        m.pc    = ID_PC;
        m.rs1   = ID_rs1_addr;
        m.rs2   = ID_rs2_addr;
        m.rd    = ID_rd;
        m.d1    = ID_rs1_data;
        m.d2    = ID_rs2_data;
        m.imm   = ID_imm;
        m.ctrl  = ID_valid ? ID_ctrl : 14'h0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("cyc_EX_valid", 32'(EX_valid), 32'(m.valid));
    checkOutput("cyc_EX_PC", EX_PC, m.pc);
    checkOutput("cyc_EX_rs1_addr", 32'(EX_rs1_addr), 32'(m.rs1));
    checkOutput("cyc_EX_rs2_addr", 32'(EX_rs2_addr), 32'(m.rs2));
    checkOutput("cyc_EX_rd", 32'(EX_rd), 32'(m.rd));
    checkOutput("cyc_EX_rs1_data", EX_rs1_data, m.d1);
    checkOutput("cyc_EX_rs2_data", EX_rs2_data, m.d2);
    checkOutput("cyc_EX_imm", EX_imm, m.imm);
    checkOutput("cyc_EX_ctrl", 32'(EX_ctrl), 32'(m.ctrl));
    checkOutput("cyc_load_use_stall", 32'(load_use_stall), 32'(model_hazard() && !flush));
`ifdef ID_EX_BUBBLE_CNT_EN
    checkOutput("cyc_bubble_cnt", bubble_cnt, m_cnt);
`endif
  end

  // Data fields are derived from the PC so every vector carries distinct payloads
  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic v,
                               input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic [13:0] ctrl);
    rst         = r;
    stall_ext   = s;
    flush       = f;
    ID_valid    = v;
    ID_PC       = pc;
    ID_rs1_addr = rs1;
    ID_rs2_addr = rs2;
    ID_rd       = rd;
    ID_Rs1_used = u1;
    ID_Rs2_used = u2;
    ID_rs1_data = pc ^ 32'hA5A5_0000;
    ID_rs2_data = pc + 32'd7;
    ID_imm      = ~pc;
    ID_ctrl     = ctrl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, C_NOP);
    tick();
    tick();
    checkOutput("reset_valid", 32'(EX_valid), 32'h0);
    checkOutput("reset_ctrl", 32'(EX_ctrl), 32'h0);
    checkOutput("reset_stall", 32'(load_use_stall), 32'h0);

    // Load x5 into EX, then add x6,x5,x7 in ID
    applyStimulus(0, 0, 0, 1, 32'h100, 5'd1, 5'd0, 5'd5, 1, 0, C_LOAD);
    tick();
    checkOutput("load_in_ex_ctrl", 32'(EX_ctrl), 32'h0840);
    checkOutput("load_in_ex_rd", 32'(EX_rd), 32'd5);
    applyStimulus(0, 0, 0, 1, 32'h104, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
    checkOutput("hazard_stall", 32'(load_use_stall), 32'h1);
    tick();
    checkOutput("bubble_valid", 32'(EX_valid), 32'h0);
    checkOutput("bubble_ctrl", 32'(EX_ctrl), 32'h0);
    checkOutput("bubble_pc", EX_PC, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h104, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
    checkOutput("after_bubble_stall", 32'(load_use_stall), 32'h0);
    tick();
    checkOutput("add_loads_pc", EX_PC, 32'h104);
    checkOutput("add_loads_rs1_data", EX_rs1_data, 32'hA5A5_0104);
    checkOutput("add_loads_valid", 32'(EX_valid), 32'h1);

    // Load to x0 never stalls
    applyStimulus(0, 0, 0, 1, 32'h108, 5'd1, 5'd0, 5'd0, 1, 0, C_LOAD);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h10C, 5'd0, 5'd7, 5'd6, 1, 1, C_ADD);
    checkOutput("rd0_no_stall", 32'(load_use_stall), 32'h0);
    tick();
    checkOutput("rd0_add_pc", EX_PC, 32'h10C);

    // Matching address but source not used
    applyStimulus(0, 0, 0, 1, 32'h110, 5'd1, 5'd0, 5'd5, 1, 0, C_LOAD);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h114, 5'd5, 5'd7, 5'd6, 0, 1, C_ADD);
    checkOutput("unused_no_stall", 32'(load_use_stall), 32'h0);
    tick();
    checkOutput("unused_add_pc", EX_PC, 32'h114);

    // Hazard through rs2
    applyStimulus(0, 0, 0, 1, 32'h118, 5'd1, 5'd0, 5'd7, 1, 0, C_LOAD);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h11C, 5'd2, 5'd7, 5'd6, 1, 1, C_ADD);
    checkOutput("rs2_stall", 32'(load_use_stall), 32'h1);
    tick();
    checkOutput("rs2_bubble_valid", 32'(EX_valid), 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h11C, 5'd2, 5'd7, 5'd6, 1, 1, C_ADD);
    tick();
    checkOutput("rs2_add_pc", EX_PC, 32'h11C);

    // Flush together with a hazard
    applyStimulus(0, 0, 0, 1, 32'h120, 5'd1, 5'd0, 5'd5, 1, 0, C_LOAD);
    tick();
    applyStimulus(0, 0, 1, 1, 32'h124, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
    checkOutput("flush_hazard_stall", 32'(load_use_stall), 32'h0);
    tick();
    checkOutput("flush_valid", 32'(EX_valid), 32'h0);
    checkOutput("flush_rd", 32'(EX_rd), 32'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkOutput("flush_cnt", bubble_cnt, 32'd3);
`endif

    // External stall holds EX across changing inputs, including a flush
    applyStimulus(0, 0, 0, 1, 32'h200, 5'd3, 5'd4, 5'd9, 1, 1, C_ADD);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, (i == 1), 1, 32'h300 + 32'(i * 4), 5'd9, 5'd9, 5'd2, 1, 1, C_LOAD);
      tick();
      checkOutput("stall_hold_pc", EX_PC, 32'h200);
      checkOutput("stall_hold_ctrl", 32'(EX_ctrl), 32'h0044);
`ifdef ID_EX_BUBBLE_CNT_EN
      checkOutput("stall_hold_cnt", bubble_cnt, 32'd3);
`endif
    end
    applyStimulus(0, 0, 0, 1, 32'h210, 5'd1, 5'd2, 5'd3, 1, 1, C_ADD);
    tick();
    checkOutput("resume_pc", EX_PC, 32'h210);

    // Invalid slot: payload copied, control forced off
    applyStimulus(0, 0, 0, 0, 32'h220, 5'd1, 5'd2, 5'd3, 1, 1, C_LOAD);
    tick();
    checkOutput("invalid_ctrl", 32'(EX_ctrl), 32'h0);
    checkOutput("invalid_valid", 32'(EX_valid), 32'h0);
    checkOutput("invalid_pc", EX_PC, 32'h220);

    applyStimulus(0, 0, 0, 1, 32'h224, 5'd1, 5'd2, 5'd3, 1, 1, C_ILL);
    tick();
    checkOutput("ill_passthrough", 32'(EX_ctrl), 32'h0001);

    // Mixed sequence of loads and dependent adds
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h400 + 32'(i * 4), 5'(i), 5'(i + 2), 5'(i + 1), 1, (i % 3 == 0),
                    (i % 2 == 0) ? C_LOAD : C_ADD);
      tick();
    end

    // Reset beats stall and flush
    applyStimulus(1, 1, 1, 1, 32'h228, 5'd1, 5'd2, 5'd3, 1, 1, C_LOAD);
    tick();
    checkOutput("rst_over_valid", 32'(EX_valid), 32'h0);
    checkOutput("rst_over_pc", EX_PC, 32'h0);
    checkOutput("rst_over_data", EX_rs1_data, 32'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkOutput("rst_over_cnt", bubble_cnt, 32'h0);

    applyStimulus(0, 0, 0, 1, 32'h500, 5'd1, 5'd0, 5'd5, 1, 0, C_LOAD);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h504, 5'd5, 5'd0, 5'd6, 1, 0, C_ADD);
    @(negedge clk);
    #1;
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    preset_toggle = ~preset_toggle;
    #1;
    release dut.bubble_cnt;
    tick();
    checkOutput("wrap_cnt", bubble_cnt, 32'h0);
`endif

    applyStimulus(0, 0, 0, 1, 32'h600, 5'd1, 5'd2, 5'd3, 1, 1, C_ADD);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
